multicycle_datapath: RTL

- Parametrised multi-cycle successor to the single-cycle datapath.
- Fetches a 32-bit instruction one byte per cycle from a loadable byte-wide instruction memory.
- Executes R-type and I-type ALU operations and writes back to a parametrised register file.
- Sits under the core top level; a testbench or loader fills the instruction memory before a run pulse.

---
 rtl/multicycle_datapath.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_datapath.sv
// multicycle_datapath: multi-cycle ALU datapath with a byte-wide, loadable
// instruction memory. Each instruction takes 6 cycles: 4 FETCH (one byte per
// cycle, big-endian), 1 EXEC, 1 WB. It executes R/I-type ALU ops and HALT.
//
// Optional feature: define DATAPATH_BRANCH_EN to enable BEQ (opcode 001011).
// Without it, that opcode is treated as unsupported.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   prog_we/addr/data byte write into instruction memory (IDLE only)
//   run               start pulse (IDLE only)
//   result, overflow  last ALU result and its signed-overflow flag
//   result_valid      one-cycle pulse when result/overflow update
//   illegal           one-cycle pulse on an unsupported opcode
//   busy, halted      FETCH/EXEC/WB and HALT state indicators
//   pc                current fetch address
module multicycle_datapath #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NREGS      = 8,
  parameter int unsigned IMEM_BYTES = 64,
  parameter int unsigned PC_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_we,
  input  logic [PC_W-1:0]   prog_addr,
  input  logic [7:0]        prog_data,
  input  logic              run,
  output logic [DATA_W-1:0] result,
  output logic              overflow,
  output logic              result_valid,
  output logic              illegal,
  output logic              busy,
  output logic              halted,
  output logic [PC_W-1:0]   pc
);

  localparam int unsigned RW = $clog2(NREGS);
  localparam int unsigned AW = $clog2(IMEM_BYTES);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_WB    = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_AND  = 6'b000010;
  localparam logic [5:0] OP_NOR  = 6'b000011;
  localparam logic [5:0] OP_OR   = 6'b000100;
  localparam logic [5:0] OP_SLT  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b000110;
  localparam logic [5:0] OP_SUBI = 6'b000111;
  localparam logic [5:0] OP_ANDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001001;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_BEQ  = 6'b001011;
  localparam logic [5:0] OP_HALT = 6'b111111;

  logic [2:0]        state_q;
  logic [1:0]        cnt_q;
  logic [PC_W-1:0]   pc_q;
  logic [31:0]       instr_q;
  logic [DATA_W-1:0] rf_q [NREGS];
  logic [DATA_W-1:0] alu_q, result_q;
  logic              ovf_q, overflow_q, wr_q, ill_q, rv_q, illegal_q;
  logic [RW-1:0]     dst_q;
  logic [7:0]        imem_q [IMEM_BYTES];

  // Decode of the held instruction (valid during EXEC and WB)
  logic [5:0]        opc;
  logic [RW-1:0]     rs_idx, rt_idx, rd_idx;
  logic [DATA_W-1:0] a, b_reg, immx, opb, sum, diff;
  logic signed [15:0] imm_s;
  logic              is_rtype, add_ovf, sub_ovf, lt;
  logic [AW-1:0]     faddr, pc_plus4;

  logic [DATA_W-1:0] alu_d;
  logic              ovf_d, wr_d, ill_d, halt_d;
  logic [RW-1:0]     dst_d;

`ifdef DATAPATH_BRANCH_EN
  logic              br_d, br_q;
  logic [AW-1:0]     br_off;
  // sext(imm)<<2 taken modulo IMEM_BYTES
  assign br_off = AW'(32'(imm_s) << 2);
`endif

  assign opc      = instr_q[31:26];
  assign rs_idx   = instr_q[21 +: RW];
  assign rt_idx   = instr_q[16 +: RW];
  assign rd_idx   = instr_q[11 +: RW];
  assign a        = (rs_idx == '0) ? '0 : rf_q[rs_idx];
  assign b_reg    = (rt_idx == '0) ? '0 : rf_q[rt_idx];
  assign imm_s    = instr_q[15:0];
  assign immx     = DATA_W'(imm_s);
  assign is_rtype = (opc <= OP_SLT);
  assign opb      = is_rtype ? b_reg : immx;
  assign sum      = a + opb;
  assign diff     = a - opb;
  assign add_ovf  = (a[DATA_W-1] == opb[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
  assign sub_ovf  = (a[DATA_W-1] != opb[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
  assign lt       = $signed(a) < $signed(opb);
  assign faddr    = pc_q[AW-1:0] + AW'(cnt_q);
  assign pc_plus4 = pc_q[AW-1:0] + AW'(4);

  always_comb begin
    alu_d  = '0;
    ovf_d  = 1'b0;
    wr_d   = 1'b1;
    ill_d  = 1'b0;
    halt_d = 1'b0;
    dst_d  = is_rtype ? rd_idx : rt_idx;
`ifdef DATAPATH_BRANCH_EN
    br_d   = 1'b0;
`endif
    case (opc)
      OP_ADD, OP_ADDI: begin alu_d = sum;  ovf_d = add_ovf; end
      OP_SUB, OP_SUBI: begin alu_d = diff; ovf_d = sub_ovf; end
      OP_AND, OP_ANDI: alu_d = a & opb;
      OP_NOR:          alu_d = ~(a | opb);
      OP_OR,  OP_ORI:  alu_d = a | opb;
      OP_SLT, OP_SLTI: alu_d = DATA_W'(lt);
      OP_HALT:         begin wr_d = 1'b0; halt_d = 1'b1; end
`ifdef DATAPATH_BRANCH_EN
      OP_BEQ:          begin wr_d = 1'b0; br_d = (a == b_reg); end
`endif
      default:         begin wr_d = 1'b0; ill_d = 1'b1; end
    endcase
  end

  // Instruction memory is intentionally outside the reset domain
  always_ff @(posedge clk) begin
    if (!rst && prog_we && state_q == S_IDLE)
      imem_q[prog_addr[AW-1:0]] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pc_q       <= '0;
      instr_q    <= '0;
      alu_q      <= '0;
      ovf_q      <= 1'b0;
      wr_q       <= 1'b0;
      ill_q      <= 1'b0;
      dst_q      <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      rv_q       <= 1'b0;
      illegal_q  <= 1'b0;
`ifdef DATAPATH_BRANCH_EN
      br_q       <= 1'b0;
`endif
      for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      rv_q      <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (run) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
          end
        end
        S_FETCH: begin
          // Shifting in 4 bytes leaves the first fetched byte in [31:24]
          instr_q <= {instr_q[23:0], imem_q[faddr]};
          cnt_q   <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (halt_d) begin
            state_q <= S_HALT;
          end else begin
            alu_q   <= alu_d;
            ovf_q   <= ovf_d;
            wr_q    <= wr_d;
            ill_q   <= ill_d;
            dst_q   <= dst_d;
`ifdef DATAPATH_BRANCH_EN
            br_q    <= br_d;
`endif
            state_q <= S_WB;
          end
        end
        S_WB: begin
          if (wr_q) begin
            result_q   <= alu_q;
            overflow_q <= ovf_q;
            rv_q       <= 1'b1;
            if (dst_q != '0) rf_q[dst_q] <= alu_q;
          end
          if (ill_q) illegal_q <= 1'b1;
`ifdef DATAPATH_BRANCH_EN
          if (br_q) pc_q <= PC_W'(pc_plus4 + br_off);
          else      pc_q <= PC_W'(pc_plus4);
`else
          pc_q <= PC_W'(pc_plus4);
`endif
          cnt_q   <= '0;
          state_q <= S_FETCH;
        end
        default: state_q <= S_HALT;
      endcase
    end
  end

  assign result       = result_q;
  assign overflow     = overflow_q;
  assign result_valid = rv_q;
  assign illegal      = illegal_q;
  assign busy         = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_WB);
  assign halted       = (state_q == S_HALT);
  assign pc           = pc_q;

endmodule
